add_sub_pipe32: RTL and testbench

//  - 32-bit two-stage pipelined adder/subtractor built from cla_4 slices; feeds the
//    RV32I ALU result mux (ADD/SUB/SLT/SLTU/branch compare).
//  - Stage 1 adds the low half; stage 2 adds the high half using the registered

---
 rtl/alu_pkg.sv | 11 +
 rtl/cla_4.sv | 28 ++
 rtl/cla_half.sv | 33 +++
 rtl/add_sub_pipe32.sv | 107 ++++++++++
 tb/tb_add_sub_pipe32.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU constants: datapath width, CLA slice width and the ALU opcode
// encodings used by the decoder alongside the add/sub pipeline.
package alu_pkg;

    localparam int ALU_W     = 32;
    localparam int CLA_SLICE = 4;

    localparam logic [3:0] ALU_OP_ADD = 4'b0000;
    localparam logic [3:0] ALU_OP_SUB = 4'b1000;

endpackage

// File: rtl/cla_4.sv
// 4-bit carry-lookahead adder slice: all internal carries are formed from
// generate/propagate terms in parallel rather than rippled.
module cla_4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:1] c;

    assign g = a & b;
    assign p = a ^ b;

    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

    assign sum  = p ^ {c[3:1], cin};
    assign cout = c[4];

endmodule

// File: rtl/cla_half.sv
// W-bit adder built from W/4 cla_4 slices with the carry chained slice to slice;
// one instance per pipeline stage.
module cla_half
    import alu_pkg::*;
#(
    parameter int W = ALU_W / 2
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    localparam int N = W / CLA_SLICE;

    logic [N:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < N; i++) begin : g_slice
        cla_4 u_cla (
            .a    (a[i*CLA_SLICE +: CLA_SLICE]),
            .b    (b[i*CLA_SLICE +: CLA_SLICE]),
            .cin  (carry[i]),
            .sum  (sum[i*CLA_SLICE +: CLA_SLICE]),
            .cout (carry[i+1])
        );
    end

    assign cout = carry[N];

endmodule

// File: rtl/add_sub_pipe32.sv
// Two-stage pipelined adder/subtractor: low half in stage 1, high half in stage 2
// from the registered mid carry. Valid/ready on both sides, 1 op/cycle.
module add_sub_pipe32
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int H = WIDTH / 2;

    logic [WIDTH-1:0] b_eff;
    logic [H-1:0]     lo_sum_n;
    logic             c_mid_n;

    logic             s1_valid;
    logic [H-1:0]     lo_sum;
    logic             c_mid;
    logic [H-1:0]     a_hi;
    logic [H-1:0]     b_eff_hi;

    logic [H-1:0]     hi_sum_n;
    logic             cout_n;
    logic             ovf_n;

    logic             s2_free;
    logic             s1_adv;
    logic             accept;

    // Subtraction is A + ~B + 1: the +1 enters as the low-half carry-in.
    assign b_eff = sub ? ~b : b;

    cla_half #(.W(H)) u_lo (
        .a    (a[H-1:0]),
        .b    (b_eff[H-1:0]),
        .cin  (sub),
        .sum  (lo_sum_n),
        .cout (c_mid_n)
    );

    cla_half #(.W(H)) u_hi (
        .a    (a_hi),
        .b    (b_eff_hi),
        .cin  (c_mid),
        .sum  (hi_sum_n),
        .cout (cout_n)
    );

    assign ovf_n = (a_hi[H-1] == b_eff_hi[H-1]) & (hi_sum_n[H-1] != a_hi[H-1]);

    assign s2_free  = !out_valid | out_ready;
    assign s1_adv   = s1_valid & s2_free;
    assign in_ready = !s1_valid | s2_free;
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // NOTE: stage-1 data registers carry no reset; s1_valid alone qualifies them.
    always_ff @(posedge clk) begin
        if (accept) begin
            lo_sum   <= lo_sum_n;
            c_mid    <= c_mid_n;
            a_hi     <= a[WIDTH-1:H];
            b_eff_hi <= b_eff[WIDTH-1:H];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else if (s1_adv) begin
            out_valid <= 1'b1;
            sum       <= {hi_sum_n, lo_sum};
            cout      <= cout_n;
            ovf       <= ovf_n;
            zero      <= ({hi_sum_n, lo_sum} == '0);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_add_sub_pipe32.sv
// Self-checking bench for add_sub_pipe32: directed corner cases, streaming,
// backpressure, mid-flight reset and random traffic against an arithmetic model.
module tb_add_sub_pipe32;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_out    = 0;
    int   n_in     = 0;

    always #5 clk = ~clk;

    add_sub_pipe32 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: unsigned and signed integer arithmetic on wide types.
    function automatic exp_t model(input logic [31:0] aa, input logic [31:0] bb, input logic s);
        exp_t           e;
        longint unsigned ua = aa;
        longint unsigned ub = bb;
        longint          sa = $signed(aa);
        longint          sb = $signed(bb);
        longint unsigned u;
        longint          r;
        if (s) begin
            u      = ua - ub;
            e.cout = (ua >= ub);
            r      = sa - sb;
        end else begin
            u      = ua + ub;
            e.cout = (u >= 64'h1_0000_0000);
            r      = sa + sb;
        end
        e.sum  = u[31:0];
        e.ovf  = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        e.zero = (e.sum == 32'd0);
        return e;
    endfunction

    // One clock: drive at negedge, check after settling, then advance to next negedge.
    task automatic step(input logic v, input logic [31:0] aa, input logic [31:0] bb,
                        input logic s, input logic ordy);
        exp_t e;
        in_valid  = v;
        a         = aa;
        b         = bb;
        sub       = s;
        out_ready = ordy;
        #1;
        check("in_ready", in_ready, !(q.size() == 2 && !ordy));
        if (out_valid && ordy) begin
            if (q.size() == 0) begin
                check("spurious_out", out_valid, 0);
            end else begin
                e = q.pop_front();
                check("sum", sum, e.sum);
                check("cout", cout, e.cout);
                check("ovf", ovf, e.ovf);
                check("zero", zero, e.zero);
                n_out++;
            end
        end else if (out_valid && q.size() > 0) begin
            check("stall_sum", sum, q[0].sum);
        end
        if (v && in_ready) begin
            q.push_back(model(aa, bb, s));
            n_in++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic directed(input string tag, input logic [31:0] aa, input logic [31:0] bb,
                            input logic s, input logic [31:0] es, input logic ec,
                            input logic eo, input logic ez);
        step(1'b1, aa, bb, s, 1'b1);
        check({tag, "_lat1"}, out_valid, 0);
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_sum"}, sum, es);
        check({tag, "_cout"}, cout, ec);
        check({tag, "_ovf"}, ovf, eo);
        check({tag, "_zero"}, zero, ez);
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() > 0; i++) step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        check("drain_empty", q.size(), 0);
    endtask

    function automatic logic [31:0] rand_operand();
        logic [31:0] corners [6];
        corners = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_FFFF, 32'h0001_0000};
        if ($urandom_range(3) == 0) return corners[$urandom_range(5)];
        return $urandom;
    endfunction

    initial begin
        int base;

        // Reset with in_valid asserted: nothing may be captured.
        rst       = 1'b1;
        in_valid  = 1'b1;
        a         = 32'h1234_5678;
        b         = 32'h1111_1111;
        sub       = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_ovf", ovf, 0);
        check("rst_zero", zero, 0);
        rst      = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("post_rst_ready", in_ready, 1);
        check("post_rst_valid", out_valid, 0);
        repeat (3) step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);

        directed("add_mid", 32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
        directed("sub_eq", 32'd5, 32'd5, 1'b1, 32'd0, 1'b1, 1'b0, 1'b1);
        directed("sub_ovf", 32'h8000_0000, 32'd1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        directed("add_ovf", 32'h7FFF_FFFF, 32'd1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        directed("wrap", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1);

        // Back-to-back stream.
        base = n_out;
        for (int i = 0; i < 8; i++) step(1'b1, 32'(i), 32'(3 * i), 1'b0, 1'b1);
        drain();
        check("stream_count", n_out - base, 8);

        // Backpressure: out_ready low for 5 cycles while streaming.
        base = n_out;
        n_in = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, $urandom, $urandom, 1'($urandom_range(1)), !(i >= 2 && i < 7));
        end
        drain();
        check("bp_count", n_out - base, n_in);

        // Mid-flight reset with two ops held in the pipe.
        step(1'b1, 32'd10, 32'd20, 1'b0, 1'b0);
        step(1'b1, 32'd30, 32'd40, 1'b0, 1'b0);
        check("mid_occupancy", q.size(), 2);
        rst      = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_valid", out_valid, 0);
        rst = 1'b0;
        q.delete();
        @(negedge clk);
        for (int i = 0; i < 6; i++) step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        check("mid_rst_quiet", out_valid, 0);

        // Random traffic with random backpressure.
        n_in = 0;
        base = n_out;
        for (int cyc = 0; cyc < 40000 && n_in < 10000; cyc++) begin
            step($urandom_range(3) != 0, rand_operand(), rand_operand(),
                 1'($urandom_range(1)), $urandom_range(9) < 7);
        end
        check("rand_accepted", n_in, 10000);
        drain();
        check("rand_count", n_out - base, n_in);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
